// File: rtl/osd_ctm_event_sched_if.sv
// DII flit stream carrying the scheduler's debug packets.
// Handshake: a flit transfers on every cycle where valid & ready are both
// high. Once valid is raised, data and last hold steady and valid stays high
// until that flit is accepted.
interface osd_ctm_event_sched_if;
  logic        valid;
  logic        last;
  logic [15:0] data;
  logic        ready;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/osd_ctm_event_sched.sv
// Core trace module event scheduler. It picks control-flow events out of the
// retired-instruction trace, queues them in a small FIFO and sends each one as
// a DII packet. Events arriving while the FIFO is full are counted, and the
// count is reported in the next packet to start.
// Optional feature macro: OSD_CTM_SCHED_PRV_EVENT_EN enables privilege-change
// events (flag bit 4 and the last-privilege register).
module osd_ctm_event_sched #(
  parameter int ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            id,
  input  logic                  cfg_enable,
  input  logic [15:0]           cfg_dest,
  input  logic [4:0]            cfg_mask,
  input  logic                  trace_valid,
  input  logic [ADDR_WIDTH-1:0] trace_pc,
  input  logic [ADDR_WIDTH-1:0] trace_npc,
  input  logic                  trace_jal,
  input  logic                  trace_jalr,
  input  logic                  trace_trap,
  input  logic                  trace_xcpt,
  input  logic [1:0]            trace_prv,
  input  logic [31:0]           trace_time,
  osd_ctm_event_sched_if.master event_out,
  output logic [15:0]           drop_cnt,
  output logic                  dbg_state
);

  localparam int PC_FLITS = ADDR_WIDTH / 16;
  localparam int N_FLITS  = 7 + 2 * PC_FLITS;
  localparam int IDX_W    = $clog2(N_FLITS);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_snap;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  logic [ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem_npc  [FIFO_DEPTH];
  logic [31:0]           r_mem_time [FIFO_DEPTH];
  logic [1:0]            r_mem_prv  [FIFO_DEPTH];
  logic [4:0]            r_mem_flags[FIFO_DEPTH];

  logic [15:0] r_drop_cnt;
  logic [15:0] r_snap;

  logic        w_prv_chg;
  logic [4:0]  w_flags;
  logic        w_capture;
  logic        w_full;
  logic        w_push;
  logic        w_drop;
  logic        w_valid;
  logic        w_accept;
  logic        w_last_flit;
  logic        w_pop;
  logic [15:0] w_data;

  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic [ADDR_WIDTH-1:0] w_head_npc;
  logic [31:0]           w_head_time;
  logic [1:0]            w_head_prv;
  logic [4:0]            w_head_flags;

`ifdef OSD_CTM_SCHED_PRV_EVENT_EN
  logic [1:0] r_last_prv;

  // Track the privilege of the last retired instruction, even while capture is off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_prv <= 2'b11;
    end else if (trace_valid) begin
      r_last_prv <= trace_prv;
    end
  end

  assign w_prv_chg = (trace_prv != r_last_prv);
`else
  assign w_prv_chg = 1'b0;
`endif

  assign w_flags = {w_prv_chg & cfg_mask[4], trace_xcpt & cfg_mask[3],
                    trace_trap & cfg_mask[2], trace_jalr & cfg_mask[1],
                    trace_jal & cfg_mask[0]};

  // A full FIFO drops the event even when the head is popped on the same edge.
  assign w_capture   = cfg_enable & trace_valid & (|w_flags);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push      = w_capture & ~w_full;
  assign w_drop      = w_capture & w_full;
  assign w_valid     = (r_state == ST_SEND);
  assign w_accept    = w_valid & event_out.ready;
  assign w_last_flit = (r_idx == IDX_W'(N_FLITS - 1));
  assign w_pop       = w_accept & w_last_flit;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  assign w_head_pc    = r_mem_pc[r_rd_ptr];
  assign w_head_npc   = r_mem_npc[r_rd_ptr];
  assign w_head_time  = r_mem_time[r_rd_ptr];
  assign w_head_prv   = r_mem_prv[r_rd_ptr];
  assign w_head_flags = r_mem_flags[r_rd_ptr];

  // Event storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= trace_pc;
      r_mem_npc[r_wr_ptr]   <= trace_npc;
      r_mem_time[r_wr_ptr]  <= trace_time;
      r_mem_prv[r_wr_ptr]   <= trace_prv;
      r_mem_flags[r_wr_ptr] <= w_flags;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Sender state register and flit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Sender next state: every packet start (from idle or back-to-back) takes a drop snapshot.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_snap      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = '0;
          w_snap      = 1'b1;
        end
      end
      ST_SEND: begin
        if (w_accept) begin
          if (w_last_flit) begin
            w_idx_nxt = '0;
            if (w_count_nxt != '0) begin
              w_state_nxt = ST_SEND;
              w_snap      = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Dropped-event counter; a snapshot hands the count to the new packet and restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drop_cnt <= '0;
      r_snap     <= '0;
    end else if (w_snap) begin
      r_snap     <= r_drop_cnt;
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Flit payload selected by index from the head entry; zero while idle.
  always_comb begin
    w_data = 16'h0000;
    case (r_idx)
      IDX_W'(0): w_data = cfg_dest;
      IDX_W'(1): w_data = {6'b0, id};
      IDX_W'(2): w_data = 16'h4000;
      IDX_W'(3): w_data = r_snap;
      IDX_W'(4): w_data = {9'b0, w_head_prv, w_head_flags};
      IDX_W'(5): w_data = w_head_time[15:0];
      IDX_W'(6): w_data = w_head_time[31:16];
      default: begin
        for (int k = 0; k < PC_FLITS; k++) begin
          if (r_idx == IDX_W'(7 + k))            w_data = w_head_pc[16*k +: 16];
          if (r_idx == IDX_W'(7 + PC_FLITS + k)) w_data = w_head_npc[16*k +: 16];
        end
      end
    endcase
  end

  assign event_out.valid = w_valid;
  assign event_out.last  = w_valid & w_last_flit;
  assign event_out.data  = w_valid ? w_data : 16'h0000;
  assign drop_cnt        = r_drop_cnt;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_osd_ctm_event_sched.sv
// Bench for osd_ctm_event_sched: directed table, hand-written corner cases and
// random traffic checked against a packet-level reference model.
module tb_osd_ctm_event_sched;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int NF    = 7 + 2 * (AW / 16);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [9:0]    id = 10'h005;
  logic          cfg_enable = 1'b1;
  logic [15:0]   cfg_dest = 16'h0003;
  logic [4:0]    cfg_mask = 5'h01;
  logic          trace_valid = 1'b0;
  logic [AW-1:0] trace_pc = '0;
  logic [AW-1:0] trace_npc = '0;
  logic          trace_jal = 1'b0;
  logic          trace_jalr = 1'b0;
  logic          trace_trap = 1'b0;
  logic          trace_xcpt = 1'b0;
  logic [1:0]    trace_prv = 2'b11;
  logic [31:0]   trace_time = '0;
  logic [15:0]   drop_cnt;
  logic          dbg_state;

  osd_ctm_event_sched_if ev_if ();

  osd_ctm_event_sched #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .id         (id),
    .cfg_enable (cfg_enable),
    .cfg_dest   (cfg_dest),
    .cfg_mask   (cfg_mask),
    .trace_valid(trace_valid),
    .trace_pc   (trace_pc),
    .trace_npc  (trace_npc),
    .trace_jal  (trace_jal),
    .trace_jalr (trace_jalr),
    .trace_trap (trace_trap),
    .trace_xcpt (trace_xcpt),
    .trace_prv  (trace_prv),
    .trace_time (trace_time),
    .event_out  (ev_if),
    .drop_cnt   (drop_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout/unexpected expected normal completion", name);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [16:0] exp_q[$];          // {last, data} for every flit still owed
  logic [15:0] snap_log[$];       // flit 3 of each accepted packet
  int          m_occ = 0;         // events held (queued or in flight)
  int          m_pos = 0;         // flit position within current packet
  int          m_drops = 0;
  int          snap_sum = 0;
  int          pkt_cnt = 0;
  logic [15:0] last_f4 = '0;
  logic [1:0]  m_last_prv = 2'b11;
  logic        hold_prev = 1'b0;
  logic [16:0] hold_flit = '0;
  int          occ_before;
  logic        m_pop;
  logic        m_prv_chg;
  logic [4:0]  m_f;

  task automatic push_packet(input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                             input logic [31:0] tm, input logic [1:0] prv, input logic [4:0] f);
    logic [AW-1:0] p;
    logic [AW-1:0] n;
    p = pc;
    n = npc;
    exp_q.push_back({1'b0, cfg_dest});
    exp_q.push_back({1'b0, 6'b0, id});
    exp_q.push_back({1'b0, 16'h4000});
    exp_q.push_back({1'b0, 16'h0000});   // drop snapshot, checked separately
    exp_q.push_back({1'b0, 9'b0, prv, f});
    exp_q.push_back({1'b0, tm[15:0]});
    exp_q.push_back({1'b0, tm[31:16]});
    for (int k = 0; k < AW / 16; k++) begin
      exp_q.push_back({1'b0, p[15:0]});
      p = p >> 16;
    end
    for (int k = 0; k < AW / 16; k++) begin
      exp_q.push_back({(k == AW / 16 - 1), n[15:0]});
      n = n >> 16;
    end
  endtask

  // Monitor: sample at the falling edge what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_valid", ev_if.valid, 1'b0);
      exp_q.delete();
      m_occ      = 0;
      m_pos      = 0;
      m_drops    = 0;
      snap_sum   = 0;
      m_last_prv = 2'b11;
      hold_prev  = 1'b0;
    end else begin
      occ_before = m_occ;
      m_pop      = 1'b0;
      if (hold_prev) begin
        check("hold_valid", ev_if.valid, 1'b1);
        check("hold_flit", {ev_if.last, ev_if.data}, hold_flit);
      end
      if (ev_if.valid) begin
        if (exp_q.size() == 0) begin
          report_fail("spurious_flit");
        end else begin
          if (m_pos == 3) check("flit_last", ev_if.last, exp_q[0][16]);
          else            check("flit", {ev_if.last, ev_if.data}, exp_q[0]);
          if (ev_if.ready) begin
            if (m_pos == 3) begin
              snap_log.push_back(ev_if.data);
              snap_sum += int'(ev_if.data);
            end
            if (m_pos == 4) last_f4 = ev_if.data;
            void'(exp_q.pop_front());
            m_pos++;
            if (m_pos == NF) begin
              m_pos = 0;
              m_pop = 1'b1;
              pkt_cnt++;
            end
          end
        end
      end
      hold_prev = ev_if.valid & ~ev_if.ready;
      hold_flit = {ev_if.last, ev_if.data};
      if (trace_valid) begin
`ifdef OSD_CTM_SCHED_PRV_EVENT_EN
        m_prv_chg = (trace_prv != m_last_prv);
`else
        m_prv_chg = 1'b0;
`endif
        m_f = {m_prv_chg & cfg_mask[4], trace_xcpt & cfg_mask[3], trace_trap & cfg_mask[2],
               trace_jalr & cfg_mask[1], trace_jal & cfg_mask[0]};
        if (cfg_enable && (m_f != 5'b0)) begin
          if (occ_before == DEPTH) begin
            m_drops++;
          end else begin
            push_packet(trace_pc, trace_npc, trace_time, trace_prv, m_f);
            m_occ++;
          end
        end
        m_last_prv = trace_prv;
      end
      if (m_pop) m_occ--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    trace_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic send_ev(input logic jal, input logic jalr, input logic trap, input logic xcpt,
                         input logic [1:0] prv, input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                         input logic [31:0] tm);
    trace_valid = 1'b1;
    trace_jal   = jal;
    trace_jalr  = jalr;
    trace_trap  = trap;
    trace_xcpt  = xcpt;
    trace_prv   = prv;
    trace_pc    = pc;
    trace_npc   = npc;
    trace_time  = tm;
    step();
    trace_valid = 1'b0;
    trace_jal   = 1'b0;
    trace_jalr  = 1'b0;
    trace_trap  = 1'b0;
    trace_xcpt  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      #1;
      if (m_occ == 0 && !ev_if.valid) done = 1'b1;
    end
    if (!done) report_fail(name);
    step();
  endtask

  task automatic wait_pos(input string name, input int p, input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      #1;
      if (m_pos == p) done = 1'b1;
    end
    if (!done) report_fail(name);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        jal;
    logic        jalr;
    logic        trap;
    logic        xcpt;
    logic [4:0]  mask;
    int          exp_pkt;
    logic [15:0] exp_f4;
  } vec_t;

  vec_t vecs[9];
  logic [15:0] exp_single[15] = '{16'h0003, 16'h0005, 16'h4000, 16'h0000, 16'h0061,
                                  16'h0002, 16'h0001, 16'h1000, 16'h8000, 16'h0000,
                                  16'h0000, 16'h2000, 16'h8000, 16'h0000, 16'h0000};
  int pkt0;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h01, 1, 16'h0061};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'h01, 0, 16'h0000};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'h02, 1, 16'h0062};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h04, 1, 16'h0064};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'h08, 1, 16'h0068};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h1F, 1, 16'h0065};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'h17, 0, 16'h0000};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h1F, 0, 16'h0000};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'h0A, 1, 16'h006A};

    ev_if.ready = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_valid", ev_if.valid, 1'b0);
    check("rst_last", ev_if.last, 1'b0);
    check("rst_data", ev_if.data, 16'h0000);
    check("rst_drop_cnt", drop_cnt, 16'h0000);
    do_reset();

    // Single jal: latency and exact packet contents.
    cfg_mask = 5'h01;
    cfg_dest = 16'h0003;
    id       = 10'h005;
    trace_valid = 1'b1;
    trace_jal   = 1'b1;
    trace_prv   = 2'b11;
    trace_pc    = 64'h0000_0000_8000_1000;
    trace_npc   = 64'h0000_0000_8000_2000;
    trace_time  = 32'h0001_0002;
    @(negedge clk);
    check("lat_cycle0_valid", ev_if.valid, 1'b0);
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
    trace_jal   = 1'b0;
    @(negedge clk);
    check("lat_cycle1_valid", ev_if.valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_valid", ev_if.valid, 1'b1);
    for (int i = 0; i < NF; i++) begin
      check($sformatf("single_flit%0d_data", i), ev_if.data, exp_single[i]);
      check($sformatf("single_flit%0d_last", i), ev_if.last, (i == NF - 1));
      @(negedge clk);
    end
    check("single_after_valid", ev_if.valid, 1'b0);
    step();

    // Table-driven single events, privilege held at 3.
    for (int v = 0; v < 9; v++) begin
      cfg_mask = vecs[v].mask;
      pkt0 = pkt_cnt;
      send_ev(vecs[v].jal, vecs[v].jalr, vecs[v].trap, vecs[v].xcpt, 2'b11,
              {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
      wait_idle($sformatf("vec%0d_drain", v), 60);
      check($sformatf("vec%0d_pkts", v), pkt_cnt - pkt0, vecs[v].exp_pkt);
      if (vecs[v].exp_pkt == 1) check($sformatf("vec%0d_flit4", v), last_f4, vecs[v].exp_f4);
    end

    // Overflow: 7 events into a stalled sink.
    do_reset();
    cfg_mask = 5'h01;
    ev_if.ready = 1'b0;
    for (int e = 0; e < 7; e++) send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, AW'(e * 16), AW'(e * 16 + 4), 32'(e));
    step();
    check("ovf_drop_cnt", drop_cnt, 16'd3);
    pkt0 = pkt_cnt;
    snap_log.delete();
    ev_if.ready = 1'b1;
    wait_idle("ovf_drain", 200);
    check("ovf_pkts", pkt_cnt - pkt0, 4);
    // The first event opened its packet (snapshot 0) before any drop, so the
    // three drops ride in the second packet; later packets see a clean count.
    if (snap_log.size() == 4) begin
      check("ovf_snap0", snap_log[0], 16'd0);
      check("ovf_snap1", snap_log[1], 16'd3);
      check("ovf_snap2", snap_log[2], 16'd0);
      check("ovf_snap3", snap_log[3], 16'd0);
    end else begin
      report_fail("ovf_snap_count");
    end
    check("ovf_drop_after", drop_cnt, 16'd0);

    // Backpressure: ready toggles every cycle.
    pkt0 = pkt_cnt;
    send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 32'hCAFE_F00D);
    for (int c = 0; c < 40; c++) begin
      ev_if.ready = ~ev_if.ready;
      step();
    end
    ev_if.ready = 1'b1;
    wait_idle("bp_drain", 60);
    check("bp_pkts", pkt_cnt - pkt0, 1);

    // Privilege change 3 -> 0 on a non-branch instruction.
    do_reset();
    cfg_mask = 5'h10;
    pkt0 = pkt_cnt;
    send_ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h100, 64'h104, 32'h55);
    wait_idle("prv_drain", 60);
`ifdef OSD_CTM_SCHED_PRV_EVENT_EN
    check("prv_pkts", pkt_cnt - pkt0, 1);
    check("prv_flit4", last_f4, 16'h0010);
`else
    check("prv_pkts", pkt_cnt - pkt0, 0);
`endif
    trace_prv = 2'b11;

    // Enable dropped mid-packet: packet completes, nothing new captured.
    do_reset();
    cfg_mask = 5'h01;
    pkt0 = pkt_cnt;
    send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 64'hA0, 64'hB0, 32'h1);
    wait_pos("en_wait_flit5", 5, 40);
    cfg_enable = 1'b0;
    step();
    for (int e = 0; e < 5; e++) send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 64'hC0, 64'hD0, 32'h2);
    wait_idle("en_drain", 60);
    check("en_pkts", pkt_cnt - pkt0, 1);
    check("en_drop_cnt", drop_cnt, 16'd0);
    cfg_enable = 1'b1;

    // Asynchronous reset while flit 8 is on the bus.
    send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 64'hE0, 64'hF0, 32'h3);
    wait_pos("rst_wait_flit8", 8, 40);
    @(posedge clk);
    #1;
    check("pre_rst_valid", ev_if.valid, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst_valid", ev_if.valid, 1'b0);
    check("async_rst_drop", drop_cnt, 16'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("post_rst_valid", ev_if.valid, 1'b0);
    step();
    pkt0 = pkt_cnt;
    send_ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 64'h1_0000_0010, 64'h2_0000_0020, 32'h4);
    wait_idle("post_rst_drain", 60);
    check("post_rst_pkts", pkt_cnt - pkt0, 1);

    // Random traffic against the model.
    do_reset();
    cfg_dest = 16'($urandom);
    id       = 10'($urandom);
    step();
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) cfg_mask = 5'($urandom_range(1, 31));
      cfg_enable  = ($urandom_range(0, 99) < 95);
      ev_if.ready = ($urandom_range(0, 99) < 75);
      trace_valid = ($urandom_range(0, 99) < 40);
      trace_jal   = ($urandom_range(0, 99) < 30);
      trace_jalr  = ($urandom_range(0, 99) < 20);
      trace_trap  = ($urandom_range(0, 99) < 10);
      trace_xcpt  = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 15) trace_prv = 2'($urandom);
      trace_pc    = {$urandom, $urandom};
      trace_npc   = {$urandom, $urandom};
      trace_time  = $urandom;
      step();
    end
    trace_valid = 1'b0;
    ev_if.ready = 1'b1;
    wait_idle("rand_drain", 400);
    check("rand_drop_total", 64'(snap_sum) + 64'(drop_cnt), 64'(m_drops));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
